// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial add/subtract sequencer for a 1-bit full-adder slice.
// Feeds one operand bit pair per cycle, LSB first, carries between cycles and
// assembles the sum in a right-shifting result register, then reports flags.
module serial_alu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] next_result;

  // Adder slice is driven only while bits are being processed
  assign fa_a   = (state == RUN) & a_sr[0];
  assign fa_b   = (state == RUN) & b_sr[0];
  assign fa_cin = (state == RUN) & carry;

  // Result as it will look after the current bit is shifted in
  assign next_result = {fa_sum, result[WIDTH-1:1]};

  // Sequencer: state, operand shifters, carry, counter and registered flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert B and seed the carry
            a_sr     <= a;
            b_sr     <= op_sub ? ~b : b;
            carry    <= op_sub;
            cnt      <= '0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          result <= next_result;
          carry  <= fa_cout;
          if (cnt == LAST_BIT) begin
            // MSB carry-in vs carry-out gives signed overflow
            c_out    <= fa_cout;
            overflow <= carry ^ fa_cout;
            zero     <= (next_result == '0);
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl with a behavioural full-adder slice.
`timescale 1ns/1ps
module tb_serial_alu_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic         busy, done;
  logic [W-1:0] result;
  logic         c_out, overflow, zero;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_sum   (fa_sum),
    .fa_cout  (fa_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  // Combinational 1-bit full-adder slice
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] result;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t         m;
    logic [W-1:0] yy;
    logic [W:0]   sum;
    yy       = s ? ~y : y;
    sum      = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
    m.result = sum[W-1:0];
    m.c      = sum[W];
    m.v      = (x[W-1] == yy[W-1]) && (sum[W-1] != x[W-1]);
    m.z      = (sum[W-1:0] == '0);
    return m;
  endfunction

  // One operation from accept to the cycle after done; poke_* are edges
  // (relative to the accepting edge 0) on which a stray start is presented.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                       input exp_t e, input int poke_a, input int poke_b);
    int   n;
    logic seen;
    int   d0;
    exp_t got;
    a = ta; b = tb_; op_sub = ts; start = 1'b1;
    sb.push_back(e);
    step();
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("result_cleared", 64'(result), 64'(0));
    n = 0;
    seen = 1'b0;
    d0 = done_cnt;
    while (!seen && n < W + 4) begin
      start = ((n + 1) == poke_a) || ((n + 1) == poke_b);
      if (start) begin a = $urandom(); b = $urandom(); op_sub = ~ts; end
      step();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'(1));
    chk("latency", 64'(n + 1), 64'(W + 1));
    if (seen) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 64'(sb.size()), 64'(1));
      end else begin
        got = sb.pop_front();
        chk("result", 64'(result), 64'(got.result));
        chk("c_out", 64'(c_out), 64'(got.c));
        chk("overflow", 64'(overflow), 64'(got.v));
        chk("zero", 64'(zero), 64'(got.z));
      end
    end else begin
      void'(sb.pop_front());
    end
    if (poke_a == n + 1 || poke_b == n + 1) begin
      start = 1'b1; a = $urandom(); b = $urandom();
    end
    step();
    start = 1'b0;
    chk("busy_falls", 64'(busy), 64'(0));
    chk("done_pulse_one_cycle", 64'(done), 64'(0));
    chk("done_count", 64'(done_cnt - d0), 64'(1));
    chk("result_held", 64'(result), 64'(e.result));
  endtask

  initial begin
    exp_t e;
    int   d0;

    vecs[0] = '{a:32'h7FFFFFFF, b:32'h00000001, sub:1'b0, r:32'h80000000, c:1'b0, v:1'b1, z:1'b0};
    vecs[1] = '{a:32'hFFFFFFFF, b:32'h00000001, sub:1'b0, r:32'h00000000, c:1'b1, v:1'b0, z:1'b1};
    vecs[2] = '{a:32'h00000000, b:32'h00000001, sub:1'b1, r:32'hFFFFFFFF, c:1'b0, v:1'b0, z:1'b0};
    vecs[3] = '{a:32'h80000000, b:32'h00000001, sub:1'b1, r:32'h7FFFFFFF, c:1'b1, v:1'b1, z:1'b0};
    vecs[4] = '{a:32'h80000000, b:32'h80000000, sub:1'b0, r:32'h00000000, c:1'b1, v:1'b1, z:1'b1};
    vecs[5] = '{a:32'h00000003, b:32'h00000005, sub:1'b1, r:32'hFFFFFFFE, c:1'b0, v:1'b0, z:1'b0};

    reset_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_flags", 64'({c_out, overflow, zero}), 64'(0));
    chk("rst_fa", 64'({fa_a, fa_b, fa_cin}), 64'(0));
    reset_n = 1'b1;
    step();

    // Table-driven directed vectors
    for (int i = 0; i < 6; i++) begin
      e = '{result:vecs[i].r, c:vecs[i].c, v:vecs[i].v, z:vecs[i].z};
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, e, -1, -1);
      step();
    end

    // Subtract to zero with stray starts at edges 5 and 33
    e = '{result:32'h0, c:1'b1, v:1'b0, z:1'b1};
    do_op(32'd5, 32'd5, 1'b1, e, 5, W + 1);
    d0 = done_cnt;
    repeat (W + 4) step();
    chk("ignored_start_no_done", 64'(done_cnt - d0), 64'(0));
    chk("ignored_start_idle", 64'(busy), 64'(0));
    chk("ignored_start_result", 64'(result), 64'(0));

    // Reset in the middle of RUN
    a = 32'h12345678; b = 32'h11111111; op_sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("mid_busy", 64'(busy), 64'(1));
    chk("mid_fa_cin_driven", 64'(fa_cin === 1'bx), 64'(0));
    reset_n = 1'b0;
    step();
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_result", 64'(result), 64'(0));
    chk("midrst_fa", 64'({fa_a, fa_b, fa_cin}), 64'(0));
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (W + 5) step();
    chk("midrst_no_done", 64'(done_cnt - d0), 64'(0));
    do_op(32'h12345678, 32'h11111111, 1'b0, model(32'h12345678, 32'h11111111, 1'b0), -1, -1);

    // Random regression with 0..3 idle cycles between operations
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, model(ra, rb, rs), -1, -1);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial sequencer for the single-bit full-adder ALU slice in the multicycle CPU datapath. It accepts a WIDTH-bit add or subtract request and drives the 1-bit adder slice with one bit pair per cycle, LSB first. It carries the running carry between cycles and shifts the sum bits into a result register. When the last bit completes, it reports the result, carry-out, signed overflow and zero flags with a one-cycle done pulse.

## Interface
- WIDTH, 32, operand/result width in bits; legal values are 2 to 64.
- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  synchronous, active-low reset, sampled on the clk rising edge.
- start  in  1  request strobe; accepted only in IDLE.
- op_sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- fa_a  out  1  bit to the adder slice A input.
- fa_b  out  1  bit to the adder slice B input.
- fa_cin  out  1  carry to the adder slice.
- fa_sum  in  1  combinational sum from the adder slice.
- fa_cout  in  1  combinational carry-out from the adder slice.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- result  out  WIDTH  sum or difference; held until the next accepted start.
- c_out  out  1  final carry; for subtract, 1 means no borrow.
- overflow  out  1  two's-complement overflow.
- zero  out  1  result == 0.

## Operation
- States:
  - IDLE: start=1 goes to RUN; otherwise stays in IDLE.
  - RUN: stays in RUN until the bit counter equals WIDTH-1, then goes to DONE.
  - DONE: always goes to IDLE after one cycle.
- On an accepted start:
  - A shift register is loaded with a.
  - B shift register is loaded with b if op_sub=0, or ~b if op_sub=1.
  - The carry register is loaded with op_sub.
  - The bit counter is cleared to 0.
  - The result register is cleared.
- RUN, combinational outputs: fa_a = A[0], fa_b = B[0], fa_cin = carry.
- RUN, each rising edge:
  - A and B shift right by one.
  - result shifts right by one, with fa_sum inserted at bit WIDTH-1.
  - carry is loaded with fa_cout.
  - The counter increments.
  - On the last bit (counter = WIDTH-1), fa_cin is also captured as msb_cin.
- After the last bit:
  - c_out = carry.
  - overflow = msb_cin XOR carry.
  - zero = (result == 0), registered on entry to DONE.
- In IDLE and DONE, fa_a, fa_b and fa_cin are driven 0.
- start is ignored while in RUN or DONE. No queueing: a request presented while busy is lost.
- result, c_out, overflow and zero keep their values through IDLE until the next accepted start. They are cleared together at that start.
- Arithmetic is modulo 2^WIDTH. The counter is ceil(log2(WIDTH)) bits wide and never wraps mid-operation.

## Timing
- Reset (reset_n=0 at a rising edge) forces:
  - state = IDLE, busy = 0, done = 0;
  - result = 0, c_out = 0, overflow = 0, zero = 0;
  - fa_a/fa_b/fa_cin = 0;
  - counter = 0, carry = 0.
- Reset takes effect in any state, including mid-RUN. No partial result is kept.
- Cycle numbering: edge 0 is the edge that samples start=1 in IDLE.
  - busy rises after edge 0.
  - RUN covers edges 1 to WIDTH.
  - done=1, with valid result and flags, in the cycle after edge WIDTH.
  - busy falls after edge WIDTH+1.
- Latency from start to done is WIDTH+1 cycles. Back-to-back start is accepted at edge WIDTH+2 at the earliest, giving a throughput of one operation per WIDTH+2 cycles.
- start=1 in the DONE cycle is ignored. start held high continuously re-triggers on every IDLE cycle.
- The adder slice is purely combinational and lies between the fa_* outputs and the fa_sum/fa_cout inputs. The slice plus shift logic must close in one clk period.

## Test plan
- Add with signed overflow, WIDTH=32: a=0x7FFFFFFF, b=0x00000001, op_sub=0 -> done at edge 33; result=0x80000000, c_out=0, overflow=1, zero=0.
- Add with wrap-around: a=0xFFFFFFFF, b=0x00000001, op_sub=0 -> result=0x00000000, c_out=1, overflow=0, zero=1.
- Subtract with borrow: a=0, b=1, op_sub=1 -> result=0xFFFFFFFF, c_out=0, overflow=0, zero=0.
- Subtract to zero: a=5, b=5, op_sub=1 -> result=0, c_out=1, zero=1.
  - The same run also pulses start at edges 5 and 33 while busy. Both pulses are ignored: exactly one done pulse and an unchanged result.
- Reset mid-operation: start a+b=0x12345678+0x11111111, assert reset_n=0 at edge 10.
  - Required: busy=0, done=0 and result=0 next cycle, and no done pulse afterwards.
  - A new start then yields 0x23456789 at edge 33 after it.
- Random regression: 1000 random a/b/op_sub pairs against a reference model, with idle gaps of 0 to 3 cycles. result, c_out and overflow must match, and done must occur exactly WIDTH+1 cycles after each accepted start.
